// File: rtl/dds_pkg.sv
// ---------------------------------------------------------------------------
// dds_pkg: shared definitions for the DDS waveform generator.
//   - wave_mode_e   : waveform select encodings driven on the mode port
//   - DEF_*         : default widths for phase accumulator, address and data
//   - quarter_sine  : elaboration-time generator for the quarter-wave ROM
// ---------------------------------------------------------------------------
package dds_pkg;

    localparam int DEF_PHASE_W = 32;
    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_DATA_W  = 8;

    localparam real MATH_PI = 3.14159265358979323846;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SAW    = 2'd3
    } wave_mode_e;

    // Entry i of a quarter-wave table with 2^rom_aw entries. Sampling at
    // (i + 0.5) keeps the table symmetric, so mirroring the index for the
    // second quadrant needs no +1 correction.
    function automatic int quarter_sine(int i, int rom_aw, int data_w);
        real amp;
        real ph;
        amp = real'((1 << (data_w - 1)) - 1);
        ph  = (MATH_PI / 2.0) * (real'(i) + 0.5) / real'(1 << rom_aw);
        return $rtoi(amp * $sin(ph) + 0.5);
    endfunction

endpackage

// File: rtl/sin_quarter_rom.sv
// ---------------------------------------------------------------------------
// sin_quarter_rom: quarter-wave sine magnitude table with a registered read.
//   clk  : rising-edge clock
//   addr : table index, ADDR_W bits (2^ADDR_W entries)
//   data : table entry one clock after addr, DATA_W bits
// Contents are computed at elaboration by dds_pkg::quarter_sine.
// ---------------------------------------------------------------------------
module sin_quarter_rom
    import dds_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W - 2,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] rom_tbl [DEPTH];
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom_tbl[i] = DATA_W'(quarter_sine(i, ADDR_W, DATA_W));
    end

    always_comb begin
        data_d = rom_tbl[addr];
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/dds_wave_gen.sv
// ---------------------------------------------------------------------------
// dds_wave_gen: direct digital synthesis waveform generator.
//   clk, rst_n  : clock and synchronous active-low reset
//   en          : advance accumulator and 3-stage pipeline when 1
//   ftw         : frequency tuning word, ftw_valid/ftw_ready handshake
//   mode        : 0 sine, 1 square, 2 triangle, 3 sawtooth
//   phase_off   : offset added to the accumulator-derived address
//   wave_data   : unsigned offset-binary sample, data_valid marks new ones
//   sync        : one-cycle pulse with the first sample after a wrap
//
// Tuning-word handshake: a word is taken on any clock where ftw_valid and
// ftw_ready are both 1. It then sits pending (ftw_ready=0) until the
// accumulator wraps, or the next clock if en=0, when it becomes the active
// rate; ftw_ready returns the cycle after. ftw_valid is ignored meanwhile.
//
// Pipeline: stage 1 address/mode/wrap, stage 2 ROM read, stage 3 shaping.
// ---------------------------------------------------------------------------
module dds_wave_gen
    import dds_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] ftw,
    input  logic               ftw_valid,
    output logic               ftw_ready,
    input  logic [1:0]         mode,
    input  logic [ADDR_W-1:0]  phase_off,
    output logic [DATA_W-1:0]  wave_data,
    output logic               data_valid,
    output logic               sync
);

    localparam int ROM_W = ADDR_W - 2;
    localparam logic [DATA_W-1:0] HALF = {1'b1, {(DATA_W-1){1'b0}}};

    // accumulator and tuning-word state
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic               wrap_q, wrap_d;
    logic [PHASE_W-1:0] ftw_act_q, ftw_act_d;
    logic [PHASE_W-1:0] ftw_pend_q, ftw_pend_d;
    logic               pend_q, pend_d;
    logic               ftw_ready_q, ftw_ready_d;

    // stage 1
    logic [ADDR_W-1:0]  addr1_q, addr1_d;
    wave_mode_e         mode1_q, mode1_d;
    logic               wrap1_q, wrap1_d;
    logic               valid1_q, valid1_d;

    // stage 2 (ROM output is the matching data for this stage)
    logic [ADDR_W-1:0]  addr2_q, addr2_d;
    wave_mode_e         mode2_q, mode2_d;
    logic               wrap2_q, wrap2_d;
    logic               valid2_q, valid2_d;

    // stage 3
    logic [DATA_W-1:0]  wave_q, wave_d;
    logic               dv_q, dv_d;
    logic               sync_q, sync_d;

    logic [PHASE_W-1:0] acc_sum;
    logic               carry;
    logic               xfer;
    logic               rom_hi;
    logic [ROM_W-1:0]   rom_lo;
    logic [ROM_W-1:0]   rom_idx;
    logic [DATA_W-1:0]  rom_data;
    logic               msb2;

    always_comb begin
        {carry, acc_sum} = {1'b0, acc_q} + {1'b0, ftw_act_q};

        // The ROM has no enable, so while stalled it re-reads the stage-2
        // address; that keeps its output paired with the held stage-2 data.
        rom_hi  = en ? addr1_q[ADDR_W-2] : addr2_q[ADDR_W-2];
        rom_lo  = en ? addr1_q[ROM_W-1:0] : addr2_q[ROM_W-1:0];
        rom_idx = rom_hi ? ~rom_lo : rom_lo;

        acc_d      = acc_q;
        wrap_d     = wrap_q;
        ftw_act_d  = ftw_act_q;
        ftw_pend_d = ftw_pend_q;
        pend_d     = pend_q;
        addr1_d    = addr1_q;
        mode1_d    = mode1_q;
        wrap1_d    = wrap1_q;
        valid1_d   = valid1_q;
        addr2_d    = addr2_q;
        mode2_d    = mode2_q;
        wrap2_d    = wrap2_q;
        valid2_d   = valid2_q;
        wave_d     = wave_q;
        msb2       = addr2_q[ADDR_W-1];

        // Carry uses the old active word, so the old rate runs up to the wrap.
        xfer = pend_q && (en ? carry : 1'b1);

        if (ftw_valid && ftw_ready_q) begin
            ftw_pend_d = ftw;
            pend_d     = 1'b1;
        end
        if (xfer) begin
            ftw_act_d = ftw_pend_q;
            pend_d    = 1'b0;
        end
        ftw_ready_d = !pend_d;

        if (en) begin
            acc_d    = acc_sum;
            wrap_d   = carry;

            addr1_d  = acc_q[PHASE_W-1 -: ADDR_W] + phase_off;
            mode1_d  = wave_mode_e'(mode);
            wrap1_d  = wrap_q;
            valid1_d = 1'b1;

            addr2_d  = addr1_q;
            mode2_d  = mode1_q;
            wrap2_d  = wrap1_q;
            valid2_d = valid1_q;

            if (valid2_q) begin
                case (mode2_q)
                    WAVE_SINE:   wave_d = msb2 ? (HALF - rom_data) : (HALF + rom_data);
                    WAVE_SQUARE: wave_d = {DATA_W{~msb2}};
                    WAVE_TRI:    wave_d = msb2 ? ~addr2_q[ADDR_W-2 -: DATA_W]
                                               :  addr2_q[ADDR_W-2 -: DATA_W];
                    default:     wave_d = addr2_q[ADDR_W-1 -: DATA_W];
                endcase
            end
        end

        dv_d   = en && valid2_q;
        sync_d = en && valid2_q && wrap2_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            wrap_q      <= 1'b0;
            ftw_act_q   <= '0;
            ftw_pend_q  <= '0;
            pend_q      <= 1'b0;
            ftw_ready_q <= 1'b1;
            addr1_q     <= '0;
            mode1_q     <= WAVE_SINE;
            wrap1_q     <= 1'b0;
            valid1_q    <= 1'b0;
            addr2_q     <= '0;
            mode2_q     <= WAVE_SINE;
            wrap2_q     <= 1'b0;
            valid2_q    <= 1'b0;
            wave_q      <= '0;
            dv_q        <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            wrap_q      <= wrap_d;
            ftw_act_q   <= ftw_act_d;
            ftw_pend_q  <= ftw_pend_d;
            pend_q      <= pend_d;
            ftw_ready_q <= ftw_ready_d;
            addr1_q     <= addr1_d;
            mode1_q     <= mode1_d;
            wrap1_q     <= wrap1_d;
            valid1_q    <= valid1_d;
            addr2_q     <= addr2_d;
            mode2_q     <= mode2_d;
            wrap2_q     <= wrap2_d;
            valid2_q    <= valid2_d;
            wave_q      <= wave_d;
            dv_q        <= dv_d;
            sync_q      <= sync_d;
        end
    end

    sin_quarter_rom #(
        .ADDR_W (ROM_W),
        .DATA_W (DATA_W)
    ) u_rom (
        .clk  (clk),
        .addr (rom_idx),
        .data (rom_data)
    );

    assign ftw_ready  = ftw_ready_q;
    assign wave_data  = wave_q;
    assign data_valid = dv_q;
    assign sync       = sync_q;

endmodule
